serial_router_core: RTL and testbench
=====================================

# serial_router_core

Parametrised N-port serial packet router core, the next generation of the team's fixed 16-port router. It accepts bit-serial frames on each input port, decodes a serial destination address, arbitrates for the destination output, and forwards the payload cut-through with one cycle of latency. It sits directly behind the testbench's driver, input-monitor and output-monitor interface signals, with port count, address width and pad length generalised.

## Interface
- NUM_PORTS, 16: input and output port count; power of two, 2..16.
- ADDR_W, $clog2(NUM_PORTS): derived; serial address bits per frame.
- PAD_CYCLES, 5: minimum cycles in PAD between the last address bit and the first payload cycle; 1..15.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  NUM_PORTS  serial data, one bit per input port.
- frame_n  in  NUM_PORTS  active-low frame; low for the whole frame, high on the last payload bit.
- valid_n  in  NUM_PORTS  active-low payload-bit valid.
- busy_n  out  NUM_PORTS  active-low; low means input i must not send payload yet.
- dout  out  NUM_PORTS  serial data per output port.
- valido_n  out  NUM_PORTS  active-low output bit valid.
- frameo_n  out  NUM_PORTS  active-low output frame.

## Operation
- Each input port runs an independent FSM with states IDLE, ADDR, PAD and DATA.
- IDLE: busy_n[i]=1. If frame_n[i]=0, sample din[i] as address bit 0 (LSB-first) and go to ADDR. With ADDR_W=1, go directly to PAD.
- ADDR: sample one address bit per cycle; valid_n is ignored. After bit ADDR_W-1, go to PAD. If frame_n[i]=1, abort to IDLE.
- PAD:
  - Request the destination output from the first PAD cycle; the pad counter increments each cycle.
  - din and valid_n are ignored.
  - Go to DATA when the grant is held and pad count ≥ PAD_CYCLES.
  - If frame_n[i]=1, abort to IDLE and drop the request or grant.
- busy_n[i]=0 in ADDR and PAD; busy_n[i]=1 in IDLE and DATA. The sender drives payload only in cycles after it samples busy_n[i]=1.
- DATA: each cycle, output port d is registered from input i:
  - dout[d] = din[i] when valid_n[i]=0, else 0.
  - valido_n[d] = valid_n[i].
  - frameo_n[d] = frame_n[i].
  - When frame_n[i]=1 is sampled (last bit), forward it, release the grant and go to IDLE.
- Arbitration, per output:
  - Requesters are inputs in PAD with address d and no grant.
  - At most one grant per output; a grant is held until the owner leaves DATA or aborts.
  - The grant is registered. A free output grants on the edge after the request is first visible.
  - An output released at edge t may be granted again at edge t+1.
- An idle (ungranted) output drives dout=0, valido_n=1, frameo_n=1.
- Multiple inputs to distinct outputs proceed fully concurrently. Any-to-self routing (i→i) is legal.

## Timing
- Reset values, applied immediately and asynchronously:
  - All FSMs go to IDLE; all grants and pad counters clear.
  - busy_n = all 1s, dout = 0, valido_n = all 1s, frameo_n = all 1s.
- Reset asserted mid-packet abandons the packet. After release, a new frame is accepted on the first edge with frame_n low.
- Latency: an input bit sampled at edge t in DATA appears on the output pins after edge t, which is 1 cycle.
- Minimum header for an uncontended frame: ADDR_W address cycles + PAD_CYCLES pad cycles. busy_n[i] rises in the cycle after the last pad cycle.
- Simultaneous release and new request on the same output: the release takes effect first, and the new grant is issued one edge later.

## Configuration
- ROUTER_RR_ARB_EN defined: per-output round-robin arbitration. The search starts at the index after the last granted input and wraps at NUM_PORTS-1 → 0.
- ROUTER_RR_ARB_EN undefined: fixed priority; the lowest input index wins.

## Test plan
- Uncontended packet, NUM_PORTS=16, PAD_CYCLES=5:
  - Stimulus: port 3 sends address 5 (bits 1,0,1,0), 5 pad cycles, then payload 0xA5 LSB-first.
  - Required: dout[5] shows 1,0,1,0,0,1,0,1, each bit 1 cycle after input.
  - Required: frameo_n[5]=1 on the last bit only; all other outputs stay idle.
- Contention:
  - Stimulus: ports 1 and 2 both address output 7 in the same cycle.
  - Required: port 1 is forwarded first, and busy_n[2] stays 0 until the edge after port 1's last bit.
  - Required: with ROUTER_RR_ARB_EN, a repeat contention is won by port 2; without it, by port 1.
- Concurrency:
  - Stimulus: 0→1 and 1→0 simultaneously with different payloads.
  - Required: both are forwarded intact with 1-cycle latency and no stall.
- Abort:
  - Stimulus: frame_n[4] rises after 2 address bits.
  - Required: port 4 returns to IDLE, busy_n[4]=1 the next cycle, no output activity, and the next frame routes correctly.
- Gap:
  - Stimulus: valid_n[0]=1 for 2 cycles mid-payload.
  - Required: valido_n[d]=1 and dout[d]=0 for those 2 cycles, and frameo_n[d] stays 0.
- Reset mid-payload:
  - Stimulus: assert reset during DATA.
  - Required: outputs immediately read dout=0, valido_n=1, frameo_n=1, busy_n all 1s, and the grant is cleared.

Source files
------------

// File: rtl/serial_router_if.sv
// Bundled bit-serial port signals of serial_router_core: per-port driver,
// input-monitor and output-monitor lines.
interface serial_router_if #(
  parameter int NUM_PORTS = 16
);
  // All lines are active-low except din/dout. A sender holds frame_n low for
  // the whole frame and raises it on the last payload bit. It drives payload
  // bits (valid_n low) only in cycles after it has sampled busy_n high.
  // valido_n/frameo_n mirror valid_n/frame_n one cycle later on the routed
  // output.
  logic [NUM_PORTS-1:0] din;
  logic [NUM_PORTS-1:0] frame_n;
  logic [NUM_PORTS-1:0] valid_n;
  logic [NUM_PORTS-1:0] busy_n;
  logic [NUM_PORTS-1:0] dout;
  logic [NUM_PORTS-1:0] valido_n;
  logic [NUM_PORTS-1:0] frameo_n;

  modport master (
    output din, frame_n, valid_n,
    input  busy_n, dout, valido_n, frameo_n
  );

  modport slave (
    input  din, frame_n, valid_n,
    output busy_n, dout, valido_n, frameo_n
  );
endinterface

// File: rtl/serial_router_core.sv
// N-port bit-serial cut-through packet router with per-output arbitration.
// ROUTER_RR_ARB_EN selects round-robin arbitration; default is fixed priority.
module serial_router_core #(
  parameter int NUM_PORTS  = 16,
  parameter int PAD_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_router_if.slave         bus,
  output logic [2*NUM_PORTS-1:0] state_dbg
);
  localparam int ADDR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  localparam logic [3:0] ADDR_LAST = 4'(ADDR_W - 1);
  localparam logic [3:0] PAD_LAST  = 4'(PAD_CYCLES - 1);

  logic [1:0]           state    [NUM_PORTS];
  logic [3:0]           addr_cnt [NUM_PORTS];
  logic [3:0]           pad_cnt  [NUM_PORTS];
  logic [ADDR_W-1:0]    addr_q   [NUM_PORTS];

  logic [NUM_PORTS-1:0] gnt_valid;
  logic [ADDR_W-1:0]    gnt_src  [NUM_PORTS];
  logic [ADDR_W-1:0]    last_src [NUM_PORTS];

  logic [NUM_PORTS-1:0] has_grant;
  logic [NUM_PORTS-1:0] release_gnt;
  logic [NUM_PORTS-1:0] req      [NUM_PORTS];
  logic [NUM_PORTS-1:0] pick_ok;
  logic [ADDR_W-1:0]    pick_src [NUM_PORTS];

  always_comb begin
    bus.busy_n = '1;
    state_dbg  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.busy_n[i]       = !(state[i] == S_ADDR || state[i] == S_PAD);
      state_dbg[2*i +: 2] = state[i];
    end
  end

  // A grant is dropped when its owner signals end of frame (last bit in DATA
  // or abort in PAD), or if the owner is somehow no longer in PAD/DATA.
  always_comb begin
    has_grant   = '0;
    release_gnt = '0;
    for (int d = 0; d < NUM_PORTS; d++) begin
      if (gnt_valid[d]) begin
        has_grant[gnt_src[d]] = 1'b1;
        release_gnt[d] = bus.frame_n[gnt_src[d]] ||
                         !(state[gnt_src[d]] == S_PAD || state[gnt_src[d]] == S_DATA);
      end
    end
  end

  // Aborting inputs (frame_n high in PAD) are masked so no grant is left stranded.
  always_comb begin
    for (int d = 0; d < NUM_PORTS; d++) begin
      req[d] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[d][i] = (state[i] == S_PAD) && !has_grant[i] && !bus.frame_n[i] &&
                    (addr_q[i] == ADDR_W'(d));
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int d = 0; d < NUM_PORTS; d++) begin
      pick_ok[d]  = 1'b0;
      pick_src[d] = '0;
`ifdef ROUTER_RR_ARB_EN
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = last_src[d] + ADDR_W'(k + 1);
        if (!pick_ok[d] && req[d][idx]) begin
          pick_ok[d]  = 1'b1;
          pick_src[d] = idx;
        end
      end
`else
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = ADDR_W'(k);
        if (!pick_ok[d] && req[d][idx]) begin
          pick_ok[d]  = 1'b1;
          pick_src[d] = idx;
        end
      end
`endif
    end
  end

  // Release has priority: a freed output is re-granted one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_valid <= '0;
      for (int d = 0; d < NUM_PORTS; d++) begin
        gnt_src[d]  <= '0;
        last_src[d] <= ADDR_W'(NUM_PORTS - 1);
      end
    end else begin
      for (int d = 0; d < NUM_PORTS; d++) begin
        if (release_gnt[d]) begin
          gnt_valid[d] <= 1'b0;
        end else if (!gnt_valid[d] && pick_ok[d]) begin
          gnt_valid[d] <= 1'b1;
          gnt_src[d]   <= pick_src[d];
          last_src[d]  <= pick_src[d];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state[i]    <= S_IDLE;
        addr_cnt[i] <= '0;
        pad_cnt[i]  <= '0;
        addr_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        case (state[i])
          S_IDLE: begin
            pad_cnt[i] <= '0;
            if (!bus.frame_n[i]) begin
              // Address arrives LSB-first, so shift in from the top.
              addr_q[i]   <= (addr_q[i] >> 1) | (ADDR_W'(bus.din[i]) << (ADDR_W - 1));
              addr_cnt[i] <= 4'd1;
              state[i]    <= (ADDR_W == 1) ? S_PAD : S_ADDR;
            end
          end
          S_ADDR: begin
            pad_cnt[i] <= '0;
            if (bus.frame_n[i]) begin
              state[i] <= S_IDLE;
            end else begin
              addr_q[i]   <= (addr_q[i] >> 1) | (ADDR_W'(bus.din[i]) << (ADDR_W - 1));
              addr_cnt[i] <= addr_cnt[i] + 4'd1;
              if (addr_cnt[i] == ADDR_LAST) state[i] <= S_PAD;
            end
          end
          S_PAD: begin
            if (bus.frame_n[i]) begin
              state[i] <= S_IDLE;
            end else if (has_grant[i] && pad_cnt[i] >= PAD_LAST) begin
              state[i] <= S_DATA;
            end else if (pad_cnt[i] != 4'hF) begin
              pad_cnt[i] <= pad_cnt[i] + 4'd1;
            end
          end
          default: begin
            if (bus.frame_n[i]) state[i] <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dout     <= '0;
      bus.valido_n <= '1;
      bus.frameo_n <= '1;
    end else begin
      for (int d = 0; d < NUM_PORTS; d++) begin
        if (gnt_valid[d] && state[gnt_src[d]] == S_DATA) begin
          bus.dout[d]     <= bus.din[gnt_src[d]] & ~bus.valid_n[gnt_src[d]];
          bus.valido_n[d] <= bus.valid_n[gnt_src[d]];
          bus.frameo_n[d] <= bus.frame_n[gnt_src[d]];
        end else begin
          bus.dout[d]     <= 1'b0;
          bus.valido_n[d] <= 1'b1;
          bus.frameo_n[d] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_router_core.sv
// Directed bench for serial_router_core (16 ports, 5 pad cycles); honours
// ROUTER_RR_ARB_EN for the repeat-contention winner.
module tb_serial_router_core;
  localparam int N   = 16;
  localparam int AW  = 4;
  localparam int PAD = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic [2*N-1:0] state_dbg;
  int             n_cmp  = 0;
  int             n_fail = 0;

  serial_router_if #(.NUM_PORTS(N)) bus ();

  serial_router_core #(.NUM_PORTS(N), .PAD_CYCLES(PAD)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [N-1:0] act);
    chk(tag, {16'h0, bus.dout & ~act, bus.valido_n | act, bus.frameo_n | act},
        {16'h0, 16'h0000, 16'hFFFF, 16'hFFFF});
  endtask

  task automatic hdr(input int pa, input int aa, input int pb, input int ab);
    for (int b = 0; b < AW; b++) begin
      bus.frame_n[pa] = 1'b0;
      bus.din[pa]     = aa[b];
      if (pb >= 0) begin
        bus.frame_n[pb] = 1'b0;
        bus.din[pb]     = ab[b];
      end
      step();
    end
    bus.din[pa] = 1'b0;
    if (pb >= 0) bus.din[pb] = 1'b0;
  endtask

  task automatic wait_busy(input int p, input string tag);
    int n;
    n = 0;
    while (bus.busy_n[p] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, bus.busy_n[p], 1);
  endtask

  // One waiting DATA cycle, then 8 payload bits LSB-first; optional 2-cycle gap before bit gap.
  task automatic pay(input int pa, input int da, input logic [7:0] va,
                     input int pb, input int db, input logic [7:0] vb,
                     input int gap, input string tag);
    logic [N-1:0] act;
    act = '0;
    act[da] = 1'b1;
    if (pb >= 0) act[db] = 1'b1;
    bus.valid_n[pa] = 1'b1;
    if (pb >= 0) bus.valid_n[pb] = 1'b1;
    step();
    chk({tag, "_wait_fo"}, bus.frameo_n[da], 0);
    chk({tag, "_wait_vo"}, bus.valido_n[da], 1);
    for (int k = 0; k < 8; k++) begin
      if (k == gap) begin
        for (int g = 0; g < 2; g++) begin
          bus.valid_n[pa] = 1'b1;
          bus.din[pa]     = 1'b1;
          step();
          chk($sformatf("%s_gap%0d", tag, g),
              {bus.dout[da], bus.valido_n[da], bus.frameo_n[da]}, 3'b010);
        end
      end
      bus.din[pa]     = va[k];
      bus.valid_n[pa] = 1'b0;
      bus.frame_n[pa] = (k == 7);
      if (pb >= 0) begin
        bus.din[pb]     = vb[k];
        bus.valid_n[pb] = 1'b0;
        bus.frame_n[pb] = (k == 7);
      end
      step();
      chk($sformatf("%s_a_bit%0d", tag, k),
          {bus.dout[da], bus.valido_n[da], bus.frameo_n[da]}, {va[k], 1'b0, k == 7});
      if (pb >= 0)
        chk($sformatf("%s_b_bit%0d", tag, k),
            {bus.dout[db], bus.valido_n[db], bus.frameo_n[db]}, {vb[k], 1'b0, k == 7});
      chk_idle($sformatf("%s_others%0d", tag, k), act);
    end
    bus.valid_n[pa] = 1'b1;
    bus.din[pa]     = 1'b0;
    if (pb >= 0) begin
      bus.valid_n[pb] = 1'b1;
      bus.din[pb]     = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int win;
    int lose;
`ifdef ROUTER_RR_ARB_EN
    win = 2;
`else
    win = 1;
`endif
    lose = 3 - win;

    reset       = 1'b1;
    bus.frame_n = '1;
    bus.valid_n = '1;
    bus.din     = '0;
    step();
    step();
    chk("rst_busy", bus.busy_n, 16'hFFFF);
    chk("rst_dout", bus.dout, 16'h0000);
    chk("rst_valido", bus.valido_n, 16'hFFFF);
    chk("rst_frameo", bus.frameo_n, 16'hFFFF);
    chk("rst_state", state_dbg, 0);
    reset = 1'b0;
    step();

    // Uncontended 3 -> 5, payload 0xA5; busy_n rises after exactly 5 pad cycles.
    hdr(3, 5, -1, 0);
    for (int c = 1; c <= PAD; c++) begin
      step();
      chk($sformatf("t1_busy_pad%0d", c), bus.busy_n[3], (c == PAD) ? 1 : 0);
      chk_idle($sformatf("t1_idle_pad%0d", c), '0);
    end
    pay(3, 5, 8'hA5, -1, 0, 8'h00, -1, "t1");
    step();
    chk("t1_busy_after", bus.busy_n[3], 1);
    chk_idle("t1_idle_after", '0);

    // Contention 1,2 -> 7: port 1 first, port 2 held busy until port 1 finishes.
    hdr(1, 7, 2, 7);
    wait_busy(1, "t2_busy1");
    chk("t2_busy2_held", bus.busy_n[2], 0);
    pay(1, 7, 8'h3C, -1, 0, 8'h00, -1, "t2a");
    chk("t2_busy2_lastbit", bus.busy_n[2], 0);
    wait_busy(2, "t2_busy2");
    pay(2, 7, 8'h96, -1, 0, 8'h00, -1, "t2b");

    // Port 1 alone to 7, then repeat contention decides by arbitration mode.
    hdr(1, 7, -1, 0);
    wait_busy(1, "t2c_busy1");
    pay(1, 7, 8'h5A, -1, 0, 8'h00, -1, "t2c");
    hdr(1, 7, 2, 7);
    wait_busy(win, "t2d_busy_win");
    chk("t2d_busy_lose_held", bus.busy_n[lose], 0);
    pay(win, 7, 8'hE1, -1, 0, 8'h00, -1, "t2d");
    chk("t2d_busy_lose_last", bus.busy_n[lose], 0);
    wait_busy(lose, "t2d_busy_lose");
    pay(lose, 7, 8'h1E, -1, 0, 8'h00, -1, "t2e");

    // Concurrency 0 -> 1 and 1 -> 0.
    hdr(0, 1, 1, 0);
    wait_busy(0, "t3_busy0");
    chk("t3_busy1_same", bus.busy_n[1], 1);
    pay(0, 1, 8'h3C, 1, 0, 8'hC3, -1, "t3");

    // Abort on port 4 after 2 address bits, then a clean frame 4 -> 2.
    bus.frame_n[4] = 1'b0;
    bus.din[4]     = 1'b1;
    step();
    bus.din[4] = 1'b0;
    step();
    chk("t4_busy_addr", bus.busy_n[4], 0);
    bus.frame_n[4] = 1'b1;
    step();
    chk("t4_busy_abort", bus.busy_n[4], 1);
    chk("t4_state_idle", state_dbg[9:8], 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_idle($sformatf("t4_idle%0d", c), '0);
    end
    hdr(4, 2, -1, 0);
    wait_busy(4, "t4_busy_new");
    pay(4, 2, 8'h69, -1, 0, 8'h00, -1, "t4");

    // Gap of 2 invalid cycles before payload bit 3, 0 -> 6.
    hdr(0, 6, -1, 0);
    wait_busy(0, "t5_busy");
    pay(0, 6, 8'hB4, -1, 0, 8'h00, 3, "t5");

    // Reset mid-payload on 6 -> 9.
    hdr(6, 9, -1, 0);
    wait_busy(6, "t6_busy");
    bus.valid_n[6] = 1'b0;
    bus.din[6]     = 1'b1;
    step();
    step();
    chk("t6_active", {bus.dout[9], bus.valido_n[9], bus.frameo_n[9]}, 3'b100);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", bus.busy_n, 16'hFFFF);
    chk("t6_rst_dout", bus.dout, 16'h0000);
    chk("t6_rst_valido", bus.valido_n, 16'hFFFF);
    chk("t6_rst_frameo", bus.frameo_n, 16'hFFFF);
    chk("t6_rst_state", state_dbg, 0);
    bus.frame_n = '1;
    bus.valid_n = '1;
    bus.din     = '0;
    step();
    reset = 1'b0;
    step();
    hdr(8, 9, -1, 0);
    for (int c = 1; c <= PAD; c++) begin
      step();
      chk($sformatf("t6_busy_pad%0d", c), bus.busy_n[8], (c == PAD) ? 1 : 0);
    end
    pay(8, 9, 8'h47, -1, 0, 8'h00, -1, "t6");
    step();
    chk_idle("t6_idle_end", '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
